// File: rtl/pixel_clk_pkg.sv
// Shared definitions for the pixel clock-enable divider.
//   state_e    : run/stop state of the divider FSM
//   MIN_DIV    : smallest divisor accepted on LOAD
//   half_ceil  : ceil(n/2), widened by one bit so the all-ones divisor cannot wrap
package pixel_clk_pkg;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int MIN_DIV = 2;

    function automatic logic [32:0] half_ceil(input logic [31:0] n);
        return ({1'b0, n} + 33'd1) >> 1;
    endfunction

endpackage

// File: rtl/div_period_counter.sv
// Period counter for the pixel clock divider.
// Counts 0..div_act-1 while run is high, flags the last count of a period
// (boundary) and produces registered PixelCLK/PixelCE for the current count.
// Ports:
//   clk, rst_n  : system clock, async active-low reset
//   run         : FSM is in RUN
//   div_act     : divisor in force for this period
//   boundary    : current cycle is the final cycle of the period (combinational)
//   pixel_clk   : high for the first ceil(N/2) counts of each period
//   pixel_ce    : high for count 0 only
module div_period_counter
    import pixel_clk_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [WIDTH-1:0] div_act,
    output logic             boundary,
    output logic             pixel_clk,
    output logic             pixel_ce
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH:0]   high_len;

    assign high_len = (WIDTH+1)'(half_ceil(32'(div_act)));
    assign boundary = run && (cnt == div_act - WIDTH'(1));

    // Outputs are registered from the count of the cycle just ending, so they
    // trail cnt by one cycle and have no combinational path from any input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            pixel_clk <= 1'b0;
            pixel_ce  <= 1'b0;
        end else begin
            pixel_clk <= run && ({1'b0, cnt} < high_len);
            pixel_ce  <= run && (cnt == '0);
            if (!run || boundary) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_clk_divider.sv
// Run-time programmable pixel clock-enable divider.
// Derives a divided square wave and a once-per-period strobe from CLK. New
// divisors and start/stop requests take effect only at period boundaries.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   STOP  | counter parked at 0, outputs low, pending divisor applied
//   RUN   | counting periods of div_act; leaves only at a boundary
//
// Ports:
//   CLK, RST  : system clock, async active-low reset
//   EN        : run request, level
//   DIV, LOAD : requested divisor and its one-cycle load strobe
//   PixelCLK  : divided clock, high ceil(N/2) / low floor(N/2) cycles
//   PixelCE   : one-cycle strobe in the first cycle of each period
//   PENDING   : a loaded divisor waits for the next boundary
//   ERR       : one-cycle pulse after a LOAD with DIV < 2
module pixel_clk_divider
    import pixel_clk_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV,
    input  logic             LOAD,
    output logic             PixelCLK,
    output logic             PixelCE,
    output logic             PENDING,
    output logic             ERR
);

    state_e           state;
    state_e           state_next;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_pend;
    logic             boundary;
    logic             apply;
    logic             load_ok;

    assign load_ok = LOAD && (DIV >= WIDTH'(MIN_DIV));
    // Divisor may change only where no period is in flight.
    assign apply   = boundary || (state == STOP);

    div_period_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk      (CLK),
        .rst_n    (RST),
        .run      (state == RUN),
        .div_act  (div_act),
        .boundary (boundary),
        .pixel_clk(PixelCLK),
        .pixel_ce (PixelCE)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= STOP;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            STOP:    if (EN) state_next = RUN;
            RUN:     if (boundary && !EN) state_next = STOP;
            default: state_next = STOP;
        endcase
    end

    // A valid LOAD landing on an apply cycle goes straight to div_act and
    // never raises PENDING; otherwise it parks in div_pend (last one wins).
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_act  <= WIDTH'(DEFAULT_DIV);
            div_pend <= WIDTH'(DEFAULT_DIV);
            PENDING  <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            ERR <= LOAD && (DIV < WIDTH'(MIN_DIV));
            if (apply) begin
                if (load_ok) begin
                    div_act <= DIV;
                end else if (PENDING) begin
                    div_act <= div_pend;
                end
                PENDING <= 1'b0;
            end else if (load_ok) begin
                div_pend <= DIV;
                PENDING  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_clk_divider.sv
module tb_pixel_clk_divider;

    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic             EN;
    logic [WIDTH-1:0] DIV;
    logic             LOAD;
    logic             PixelCLK;
    logic             PixelCE;
    logic             PENDING;
    logic             ERR;
    logic [3:0]       obs;

    int checks = 0;
    int errors = 0;

    pixel_clk_divider #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .DIV     (DIV),
        .LOAD    (LOAD),
        .PixelCLK(PixelCLK),
        .PixelCE (PixelCE),
        .PENDING (PENDING),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    assign obs = {PixelCLK, PixelCE, PENDING, ERR};

    // Reference model: whole periods are expanded into a queue of
    // {PixelCLK, PixelCE} samples when they start; an empty queue means stopped.
    logic [1:0] wave_q[$];
    int         m_act;
    int         m_pend_val;
    bit         m_pend;
    bit         m_err;
    bit         m_clk;
    bit         m_ce;

    function automatic void model_reset();
        wave_q.delete();
        m_act      = DEFAULT_DIV;
        m_pend_val = DEFAULT_DIV;
        m_pend     = 1'b0;
        m_err      = 1'b0;
        m_clk      = 1'b0;
        m_ce       = 1'b0;
    endfunction

    function automatic void push_period(input int n);
        for (int i = 0; i < n; i++) begin
            wave_q.push_back({(i < (n + 1) / 2) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0});
        end
    endfunction

    function automatic logic [3:0] exp_vec();
        return {m_clk, m_ce, m_pend, m_err};
    endfunction

    // Advance one clock edge, update the model with the inputs seen at that
    // edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        logic [1:0] o;
        bit         running;
        bit         bnd;
        bit         valid;
        @(posedge CLK);
        if (!RST) begin
            model_reset();
        end else begin
            running = (wave_q.size() != 0);
            o       = running ? wave_q.pop_front() : 2'b00;
            bnd     = running && (wave_q.size() == 0);
            valid   = LOAD && (int'(DIV) >= 2);
            if (!running || bnd) begin
                if (valid) begin
                    m_act  = int'(DIV);
                    m_pend = 1'b0;
                end else if (m_pend) begin
                    m_act  = m_pend_val;
                    m_pend = 1'b0;
                end
                if (EN) push_period(m_act);
            end else if (valid) begin
                m_pend_val = int'(DIV);
                m_pend     = 1'b1;
            end
            m_err = LOAD && (int'(DIV) < 2);
            m_clk = o[1];
            m_ce  = o[0];
        end
        #1;
    endtask

    task automatic test_reset();
        RST  = 1'b0;
        EN   = 1'b0;
        LOAD = 1'b0;
        DIV  = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0000", obs);
        end
        RST = 1'b1;
        tick();
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle got %b exp %b", obs, exp_vec());
        end
    endtask

    task automatic test_default_run();
        logic [3:0] clk_pat;
        clk_pat = 4'b1100;
        EN = 1'b1;
        tick();
        checks++;
        if (PixelCE !== 1'b0) begin
            errors++;
            $display("FAIL start_latency_early got ce=%b exp 0", PixelCE);
        end
        tick();
        checks++;
        if ({PixelCLK, PixelCE} !== 2'b11) begin
            errors++;
            $display("FAIL start_first_ce got %b exp 11", {PixelCLK, PixelCE});
        end
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL default_run cyc %0d got %b exp %b", i, obs, exp_vec());
            end
            checks++;
            if (PixelCLK !== clk_pat[3 - (i % 4)] || PixelCE !== ((i % 4) == 0)) begin
                errors++;
                $display("FAIL default_pattern cyc %0d got %b%b exp %b%b", i, PixelCLK, PixelCE,
                         clk_pat[3 - (i % 4)], (i % 4) == 0);
            end
        end
    endtask

    task automatic test_load_pending();
        bit found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wave_q.size() == 3 && m_act == 4) begin
                found = 1'b1;
                break;
            end
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL pend_wait got %b exp %b", obs, exp_vec());
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL pend_wait_timeout got none exp k=1 of N=4");
        end
        LOAD = 1'b1;
        DIV  = 8'd5;
        tick();
        LOAD = 1'b0;
        checks++;
        if (PENDING !== 1'b1) begin
            errors++;
            $display("FAIL pend_set got %b exp 1", PENDING);
        end
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL load_pending cyc %0d got %b exp %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_err();
        for (int v = 1; v >= 0; v--) begin
            LOAD = 1'b1;
            DIV  = WIDTH'(v);
            tick();
            LOAD = 1'b0;
            checks++;
            if (ERR !== 1'b1 || PENDING !== 1'b0) begin
                errors++;
                $display("FAIL err_pulse div=%0d got err=%b pend=%b exp err=1 pend=0", v, ERR, PENDING);
            end
            for (int i = 0; i < 6; i++) begin
                tick();
                checks++;
                if (obs !== exp_vec()) begin
                    errors++;
                    $display("FAIL err_after div=%0d cyc %0d got %b exp %b", v, i, obs, exp_vec());
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wave_q.size() == m_act && m_act >= 3) begin
                found = 1'b1;
                break;
            end
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_wait got %b exp %b", obs, exp_vec());
            end
        end
        LOAD = 1'b1;
        DIV  = 8'd3;
        tick();
        DIV  = 8'd6;
        tick();
        LOAD = 1'b0;
        checks++;
        if (PENDING !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pending got %b exp 1", PENDING);
        end
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (wave_q.size() == 1 && m_act == 6) begin
                found = 1'b1;
                break;
            end
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_run6 got %b exp %b", obs, exp_vec());
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL b2b_boundary_timeout got none exp N=6 boundary");
        end
        LOAD = 1'b1;
        DIV  = 8'd2;
        tick();
        LOAD = 1'b0;
        checks++;
        if (PENDING !== 1'b0) begin
            errors++;
            $display("FAIL b2b_bypass got pend=%b exp 0", PENDING);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_run2 cyc %0d got %b exp %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_stop();
        bit found = 1'b0;
        LOAD = 1'b1;
        DIV  = 8'd4;
        tick();
        LOAD = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wave_q.size() == 3 && m_act == 4) begin
                found = 1'b1;
                break;
            end
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL stop_wait got %b exp %b", obs, exp_vec());
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL stop_wait_timeout got none exp k=1 of N=4");
        end
        EN = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL stop_run cyc %0d got %b exp %b", i, obs, exp_vec());
            end
        end
        checks++;
        if ({PixelCLK, PixelCE} !== 2'b00) begin
            errors++;
            $display("FAIL stop_final got %b exp 00", {PixelCLK, PixelCE});
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        EN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (wave_q.size() == 2 && m_act == 4) begin
                found = 1'b1;
                break;
            end
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_wait got %b exp %b", obs, exp_vec());
            end
        end
        LOAD = 1'b1;
        DIV  = 8'd7;
        tick();
        LOAD = 1'b0;
        checks++;
        if (PENDING !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pending got %b exp 1", PENDING);
        end
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_async got %b exp 0000", obs);
        end
        model_reset();
        tick();
        RST = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_after cyc %0d got %b exp %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_max_div();
        bit found = 1'b0;
        int highs;
        int ces;
        LOAD = 1'b1;
        DIV  = 8'd255;
        tick();
        LOAD = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wave_q.size() == 255 && m_act == 255) begin
                found = 1'b1;
                break;
            end
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL max_wait got %b exp %b", obs, exp_vec());
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL max_wait_timeout got none exp N=255 start");
        end
        for (int p = 0; p < 2; p++) begin
            highs = 0;
            ces   = 0;
            for (int i = 0; i < 255; i++) begin
                tick();
                highs += int'(PixelCLK);
                ces   += int'(PixelCE);
                checks++;
                if (obs !== exp_vec()) begin
                    errors++;
                    $display("FAIL max_run p%0d cyc %0d got %b exp %b", p, i, obs, exp_vec());
                end
            end
            checks++;
            if (highs != 128 || ces != 1) begin
                errors++;
                $display("FAIL max_period p%0d got high=%0d ce=%0d exp high=128 ce=1", p, highs, ces);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) EN = ~EN;
            LOAD = ($urandom_range(0, 7) == 0);
            DIV  = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 255))
                                               : WIDTH'($urandom_range(0, 9));
            RST  = ($urandom_range(0, 399) != 0);
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d got %b exp %b", c, obs, exp_vec());
            end
        end
        RST  = 1'b1;
        LOAD = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default_run();
        test_load_pending();
        test_err();
        test_back_to_back();
        test_stop();
        test_reset_mid();
        test_max_div();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_clk_divider.md
# pixel_clk_divider

Parametrised, run-time programmable clock-enable divider that replaces the fixed pixel-clock divider in the display path. It derives a divided square wave (PixelCLK) and a one-cycle period strobe (PixelCE) from the system clock. The divisor is reloadable at run time and takes effect only at period boundaries, so the output never glitches. Start/stop is gated so periods are never truncated; downstream timing generators consume PixelCE as their clock enable.

## Interface
- WIDTH, 8: divisor width in bits.
- DEFAULT_DIV, 4: divisor in force after reset. Legal range 2..2^WIDTH-1.
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  reset, asynchronous assert, active-low (0 = reset).
- EN  in  1  run request, level-sensitive.
- DIV  in  WIDTH  requested divisor, sampled when LOAD=1.
- LOAD  in  1  divisor load strobe, one cycle.
- PixelCLK  out  1  divided clock: high ceil(N/2) cycles, low floor(N/2) cycles.
- PixelCE  out  1  one-cycle strobe in the first cycle of each period.
- PENDING  out  1  a loaded divisor is waiting for the next boundary.
- ERR  out  1  one-cycle pulse when a LOAD is rejected (DIV<2).

## Operation
- Internal state: div_act (divisor in force), div_pend, cnt (WIDTH bits, counts 0..div_act-1), FSM {STOP, RUN}.
- Reset state:
  - STOP, cnt=0, div_act=DEFAULT_DIV, div_pend=DEFAULT_DIV.
  - PixelCLK=0, PixelCE=0, PENDING=0, ERR=0.
- STOP:
  - cnt held at 0, outputs 0.
  - EN=1 sampled at an edge → RUN with cnt=0.
- RUN, cycle with count k:
  - PixelCLK = (k < ceil(div_act/2)).
  - PixelCE = (k == 0).
  - Increment cnt. At k = div_act-1 (the boundary), wrap to 0.
- At a boundary with EN=0 → STOP, outputs 0 next cycle. A period is never cut short; EN changes mid-period have no effect until the boundary.
- LOAD with DIV≥2:
  - Sets div_pend=DIV, PENDING=1.
  - A later LOAD before the boundary overwrites div_pend (last wins).
- LOAD with DIV<2:
  - Ignored: div_pend and PENDING unchanged.
  - ERR=1 for exactly the next cycle.
- Divisor application:
  - At each boundary, and on any cycle while in STOP: if PENDING, div_act←div_pend and PENDING←0.
  - A valid LOAD in the same cycle as a boundary (or in STOP) bypasses the pending register: DIV becomes div_act at that edge, and PENDING stays 0.
- Arithmetic: ceil(N/2) = (N+1)>>1, computed in WIDTH+1 bits so that N = 2^WIDTH-1 cannot overflow.

## Timing
- All outputs registered; no combinational path from input to output.
- Start latency: EN high at edge t → PixelCLK=1 and PixelCE=1 visible after edge t+1.
- Divisor change latency: at most one full old-divisor period.
- Stop latency: EN low → outputs drop after the current period's final cycle.
- Waveforms:
  - N=2: PixelCLK 10, PixelCE 10.
  - N=4: PixelCLK 1100, PixelCE 1000.
  - N=5: PixelCLK 11100, PixelCE 10000.
- Reset asserted mid-period: all outputs 0 immediately (asynchronous); any pending divisor is discarded; div_act returns to DEFAULT_DIV.
- Reset deassertion is synchronised externally; the block's first sampled edge after release is treated as STOP.

## Structure
- Shared package pixel_clk_pkg:
  - State enum {STOP, RUN}.
  - Constant MIN_DIV=2.
  - Function half_ceil(N).
- One sub-module, div_period_counter: cnt register, boundary detect, PixelCLK/PixelCE generation from div_act.
- The top level holds the FSM, the load/pending/error logic and the divisor register.

## Test plan
- Reset, EN=1, no LOAD → PixelCLK 1100 repeating, PixelCE 1000; first PixelCE one cycle after EN is sampled.
- LOAD DIV=5 at k=1 of an N=4 period → PENDING=1 until the boundary; the next period is 11100; PENDING clears at the boundary edge.
- LOAD DIV=1, then DIV=0 → ERR one-cycle pulse each; waveform unchanged; PENDING stays 0.
- LOAD DIV=3 then DIV=6 in the same period; LOAD DIV=2 coincident with a boundary → period 111000 applied, then 10 applied immediately with PENDING never set for the 2.
- EN dropped at k=1 of N=4 → period completes (1100), then outputs 0. Assert RST low mid-period with a pending load → outputs 0 immediately; after release, N=4 restored.
- DIV=2^WIDTH-1 (255): high 128 cycles, low 127 cycles, PixelCE every 255 cycles, no counter overflow.
